// File: rtl/swap_grid_driver.sv
// Serializes one swap-grid job onto the engine's value/mode lines and collects its 9-beat burst.
// Build macro SWAP_CHECK_EN adds an internal swap model that reports result mismatches as err 3.
module swap_grid_driver #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_job_valid,
    output logic        o_job_ready,
    input  logic [53:0] i_job_vals,
    input  logic [39:0] i_job_modes,
    output logic        o_res_valid,
    output logic [53:0] o_res_vals,
    output logic [1:0]  o_res_err,
    output logic        o_in_valid1,
    output logic [5:0]  o_in,
    output logic        o_in_valid2,
    output logic [3:0]  o_mode,
    input  logic        i_out_valid,
    input  logic [5:0]  i_out
);
    typedef enum logic [2:0] {
        StIdle, StCheck, StSend, StWait, StCollect, StGap, StDone
    } state_e;

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            r_state, w_state;
    logic [53:0]       r_vals, w_vals;
    logic [39:0]       r_modes, w_modes;
    logic [3:0]        r_beat, w_beat, w_idx;
    logic [CntW-1:0]   r_cnt, w_cnt;
    logic [53:0]       r_cap, w_cap;
    logic [1:0]        r_err, w_err;
    logic              r_job_ready, r_res_valid, r_in_valid1, r_in_valid2;
    logic              w_in_valid1, w_in_valid2;
    logic [5:0]        r_in, w_in;
    logic [3:0]        r_mode, w_mode;
    logic [53:0]       r_res_vals, w_res_vals;
    logic [1:0]        r_res_err, w_res_err;

    function automatic logic job_bad(input logic [53:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (v[6*i +: 6] == 6'd0) bad = 1'b1;
            for (int j = i + 1; j < 9; j++) begin
                if (v[6*i +: 6] == v[6*j +: 6]) bad = 1'b1;
            end
        end
        return bad;
    endfunction

`ifdef SWAP_CHECK_EN
    logic [53:0] r_model, w_model;

    function automatic logic [53:0] apply_swap(input logic [53:0] v, input logic [3:0] m);
        logic [53:0] r;
        int unsigned a, b;
        r = v;
        case (m)
            4'd1:    begin a = 0; b = 1; end
            4'd2:    begin a = 1; b = 2; end
            4'd3:    begin a = 0; b = 3; end
            4'd4:    begin a = 1; b = 4; end
            4'd5:    begin a = 2; b = 5; end
            4'd6:    begin a = 3; b = 4; end
            4'd7:    begin a = 4; b = 5; end
            4'd8:    begin a = 3; b = 6; end
            4'd9:    begin a = 4; b = 7; end
            4'd10:   begin a = 5; b = 8; end
            4'd11:   begin a = 6; b = 7; end
            4'd12:   begin a = 7; b = 8; end
            default: begin a = 0; b = 0; end
        endcase
        r[6*a +: 6] = v[6*b +: 6];
        r[6*b +: 6] = v[6*a +: 6];
        return r;
    endfunction
`endif

    always_comb begin
        w_state     = r_state;
        w_vals      = r_vals;
        w_modes     = r_modes;
        w_beat      = r_beat;
        w_idx       = r_beat + 4'd1;
        w_cnt       = r_cnt;
        w_cap       = r_cap;
        w_err       = r_err;
        w_in_valid1 = 1'b0;
        w_in        = 6'd0;
        w_in_valid2 = 1'b0;
        w_mode      = 4'd0;
        w_res_vals  = r_res_vals;
        w_res_err   = r_res_err;
`ifdef SWAP_CHECK_EN
        w_model     = r_model;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_job_valid && r_job_ready) begin
                    w_state = StCheck;
                    w_vals  = i_job_vals;
                    w_modes = i_job_modes;
                    w_cap   = '0;
                    w_err   = 2'd0;
                end
            end
            StCheck: begin
`ifdef SWAP_CHECK_EN
                w_model = r_vals;
`endif
                if (job_bad(r_vals)) begin
                    w_state = StDone;
                    w_err   = 2'd1;
                end else begin
                    w_state     = StSend;
                    w_beat      = 4'd0;
                    w_in_valid1 = 1'b1;
                    w_in        = r_vals[5:0];
                    w_in_valid2 = 1'b1;
                    w_mode      = r_modes[3:0];
                end
            end
            StSend: begin
`ifdef SWAP_CHECK_EN
                w_model = apply_swap(r_model, r_modes[4*r_beat +: 4]);
`endif
                if (r_beat == 4'd9) begin
                    w_state = StWait;
                    w_cnt   = '0;
                end else begin
                    w_beat      = w_idx;
                    w_in_valid1 = 1'b1;
                    w_in_valid2 = 1'b1;
                    w_mode      = r_modes[4*w_idx +: 4];
                    // Beat 9 carries the zero terminator instead of a slot value
                    if (r_beat != 4'd8) w_in = r_vals[6*w_idx +: 6];
                end
            end
            StWait: begin
                if (i_out_valid) begin
                    w_state    = StCollect;
                    w_cap[5:0] = i_out;
                    w_beat     = 4'd1;
                end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                    w_state = StDone;
                    w_err   = 2'd2;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StCollect: begin
                if (!i_out_valid) begin
                    w_state = StDone;
                    w_err   = 2'd2;
                end else begin
                    w_cap[6*r_beat +: 6] = i_out;
                    if (r_beat == 4'd8) begin
                        w_state = StGap;
                        w_beat  = 4'd0;
                    end else begin
                        w_beat = w_idx;
                    end
                end
            end
            StGap: begin
                if (r_beat == 4'd0) begin
                    if (i_out_valid) w_err = 2'd2;
                    w_beat = 4'd1;
                end else begin
                    w_state = StDone;
                end
            end
            StDone:  w_state = StIdle;
            default: w_state = StIdle;
        endcase

        if (w_state == StDone) begin
            w_res_vals = w_cap;
            w_res_err  = w_err;
`ifdef SWAP_CHECK_EN
            if (w_err == 2'd0 && w_cap != r_model) w_res_err = 2'd3;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_vals      <= '0;
            r_modes     <= '0;
            r_beat      <= '0;
            r_cnt       <= '0;
            r_cap       <= '0;
            r_err       <= '0;
            r_job_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_in_valid1 <= 1'b0;
            r_in        <= '0;
            r_in_valid2 <= 1'b0;
            r_mode      <= '0;
            r_res_vals  <= '0;
            r_res_err   <= '0;
        end else begin
            r_state     <= w_state;
            r_vals      <= w_vals;
            r_modes     <= w_modes;
            r_beat      <= w_beat;
            r_cnt       <= w_cnt;
            r_cap       <= w_cap;
            r_err       <= w_err;
            r_job_ready <= (w_state == StIdle);
            r_res_valid <= (w_state == StDone);
            r_in_valid1 <= w_in_valid1;
            r_in        <= w_in;
            r_in_valid2 <= w_in_valid2;
            r_mode      <= w_mode;
            r_res_vals  <= w_res_vals;
            r_res_err   <= w_res_err;
        end
    end

`ifdef SWAP_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) r_model <= '0;
        else       r_model <= w_model;
    end
`endif

    assign o_job_ready = r_job_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_vals  = r_res_vals;
    assign o_res_err   = r_res_err;
    assign o_in_valid1 = r_in_valid1;
    assign o_in        = r_in;
    assign o_in_valid2 = r_in_valid2;
    assign o_mode      = r_mode;

endmodule

// File: tb/tb_swap_grid_driver.sv
// Bench for swap_grid_driver: a per-cycle timeline model built from job descriptions, checked
// against the DUT on every cycle, plus literal result pins. Honours SWAP_CHECK_EN.
`timescale 1ns/1ps
module tb_swap_grid_driver;
    localparam int T    = 8;
    localparam int MAXC = 1024;

    logic        clk;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [53:0] job_vals;
    logic [39:0] job_modes;
    logic        res_valid;
    logic [53:0] res_vals;
    logic [1:0]  res_err;
    logic        in_valid1;
    logic [5:0]  in_data;
    logic        in_valid2;
    logic [3:0]  mode;
    logic        out_valid;
    logic [5:0]  out_data;

    swap_grid_driver #(.TIMEOUT(T)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_job_valid (job_valid),
        .o_job_ready (job_ready),
        .i_job_vals  (job_vals),
        .i_job_modes (job_modes),
        .o_res_valid (res_valid),
        .o_res_vals  (res_vals),
        .o_res_err   (res_err),
        .o_in_valid1 (in_valid1),
        .o_in        (in_data),
        .o_in_valid2 (in_valid2),
        .o_mode      (mode),
        .i_out_valid (out_valid),
        .i_out       (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Label n = DUT outputs as they stand after posedge number n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        e_rdy  [MAXC];
    logic        e_rv   [MAXC];
    logic        e_iv1  [MAXC];
    logic        e_iv2  [MAXC];
    logic [5:0]  e_in   [MAXC];
    logic [3:0]  e_mode [MAXC];
    logic [53:0] e_vals [MAXC];
    logic        e_vk   [MAXC];
    logic [1:0]  e_err  [MAXC];
    logic        pin_ve [MAXC];
    logic [53:0] pin_vv [MAXC];
    logic        pin_ee [MAXC];
    logic [1:0]  pin_ev [MAXC];

    int n_chk = 0;
    int n_err = 0;

    localparam logic [53:0] L19  = 54'b001001_001000_000111_000110_000101_000100_000011_000010_000001;
    localparam logic [53:0] L231 = 54'b001001_001000_000111_000110_000101_000100_000001_000011_000010;
    localparam logic [53:0] L18  = 54'b000000_001000_000111_000110_000101_000100_000011_000010_000001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s label=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [53:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (v[6*i +: 6] == 6'd0) bad = 1'b1;
            for (int j = 0; j < i; j++) if (v[6*i +: 6] == v[6*j +: 6]) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [53:0] ref_swap(input logic [53:0] v, input logic [39:0] m);
        logic [5:0]  s [9];
        logic [5:0]  t;
        logic [53:0] r;
        int a, b;
        for (int i = 0; i < 9; i++) s[i] = v[6*i +: 6];
        for (int k = 0; k < 10; k++) begin
            case (m[4*k +: 4])
                4'd1: begin a = 0; b = 1; end
                4'd2: begin a = 1; b = 2; end
                4'd3: begin a = 0; b = 3; end
                4'd4: begin a = 1; b = 4; end
                4'd5: begin a = 2; b = 5; end
                4'd6: begin a = 3; b = 4; end
                4'd7: begin a = 4; b = 5; end
                4'd8: begin a = 3; b = 6; end
                4'd9: begin a = 4; b = 7; end
                4'd10: begin a = 5; b = 8; end
                4'd11: begin a = 6; b = 7; end
                4'd12: begin a = 7; b = 8; end
                default: begin a = 0; b = 0; end
            endcase
            t = s[a]; s[a] = s[b]; s[b] = t;
        end
        for (int i = 0; i < 9; i++) r[6*i +: 6] = s[i];
        return r;
    endfunction

    // Offer a job, record the expected timeline, then play the engine's burst of blen beats
    task automatic run_job(input logic [53:0] v, input logic [39:0] m, input int blen,
                           input logic [59:0] burst, input int lat, input bit pve,
                           input logic [53:0] pv, input bit pee, input logic [1:0] pe);
        int a, d, l;
        logic bad;
        logic [1:0] err;
        logic [53:0] got;
        a   = cyc + 1;
        l   = a + 11 + lat;
        bad = ref_bad(v);
        got = '0;
        job_valid = 1'b1;
        job_vals  = v;
        job_modes = m;
        if (bad) begin
            d   = a + 1;
            err = 2'd1;
        end else begin
            for (int k = 0; k < 10; k++) begin
                e_iv1[a+1+k]  = 1'b1;
                e_iv2[a+1+k]  = 1'b1;
                e_mode[a+1+k] = m[4*k +: 4];
                if (k < 9) e_in[a+1+k] = v[6*k +: 6];
            end
            if (blen == 0)     d = a + 11 + T;
            else if (blen < 9) d = l + blen + 1;
            else               d = l + 11;
            for (int j = 0; j < 9 && j < blen; j++) got[6*j +: 6] = burst[6*j +: 6];
            err = (blen != 9) ? 2'd2 : 2'd0;
`ifdef SWAP_CHECK_EN
            if (err == 2'd0 && got != ref_swap(v, m)) err = 2'd3;
`endif
        end
        for (int c = a; c <= d; c++) e_rdy[c] = 1'b0;
        e_rv[d] = 1'b1;
        for (int c = d; c < MAXC; c++) begin
            e_err[c]  = err;
            e_vals[c] = got;
            e_vk[c]   = !bad;
        end
        pin_ve[d] = pve; pin_vv[d] = pv;
        pin_ee[d] = pee; pin_ev[d] = pe;

        @(posedge clk); #1;
        job_valid = 1'b0;
        if (!bad && blen > 0) begin
            repeat (l - a) @(posedge clk);
            #1;
            for (int j = 0; j < blen; j++) begin
                out_valid = 1'b1;
                out_data  = burst[6*j +: 6];
                @(posedge clk); #1;
            end
            out_valid = 1'b0;
            out_data  = 6'd0;
        end
        while (cyc < d + 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_reset_job(input logic [53:0] v, input logic [39:0] m);
        int a;
        a = cyc + 1;
        job_valid = 1'b1;
        job_vals  = v;
        job_modes = m;
        for (int k = 0; k < 6; k++) begin
            e_iv1[a+1+k]  = 1'b1;
            e_iv2[a+1+k]  = 1'b1;
            e_mode[a+1+k] = m[4*k +: 4];
            e_in[a+1+k]   = v[6*k +: 6];
        end
        for (int c = a; c <= a + 6; c++) e_rdy[c] = 1'b0;
        for (int c = a + 7; c < MAXC; c++) begin
            e_err[c]  = 2'd0;
            e_vals[c] = '0;
            e_vk[c]   = 1'b1;
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                if (cyc == 1) chk("reset_job_ready", 64'(job_ready), 64'd1);
                chk("job_ready", 64'(job_ready), 64'(e_rdy[cyc]));
                chk("res_valid", 64'(res_valid), 64'(e_rv[cyc]));
                chk("in_valid1", 64'(in_valid1), 64'(e_iv1[cyc]));
                chk("in", 64'(in_data), 64'(e_in[cyc]));
                chk("in_valid2", 64'(in_valid2), 64'(e_iv2[cyc]));
                chk("mode", 64'(mode), 64'(e_mode[cyc]));
                chk("res_err", 64'(res_err), 64'(e_err[cyc]));
                if (e_vk[cyc])   chk("res_vals", 64'(res_vals), 64'(e_vals[cyc]));
                if (pin_ve[cyc]) chk("pin_res_vals", 64'(res_vals), 64'(pin_vv[cyc]));
                if (pin_ee[cyc]) chk("pin_res_err", 64'(res_err), 64'(pin_ev[cyc]));
            end
        end
    end

    initial begin
        logic [53:0] vb, vz, vx;
        logic [1:0]  e9;
        for (int c = 0; c < MAXC; c++) begin
            e_rdy[c] = 1'b1; e_rv[c] = 1'b0; e_iv1[c] = 1'b0; e_iv2[c] = 1'b0;
            e_in[c] = 6'd0; e_mode[c] = 4'd0; e_vals[c] = '0; e_vk[c] = 1'b1; e_err[c] = 2'd0;
            pin_ve[c] = 1'b0; pin_vv[c] = '0; pin_ee[c] = 1'b0; pin_ev[c] = 2'd0;
        end
        rst = 1'b1; job_valid = 1'b0; job_vals = '0; job_modes = '0;
        out_valid = 1'b0; out_data = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        vb = L19; vb[5:0] = 6'd5;
        vz = L19; vz[53:48] = 6'd0;
        vx = {6'd28, 6'd19, 6'd50, 6'd2, 6'd41, 6'd33, 6'd12, 6'd7, 6'd63};
`ifdef SWAP_CHECK_EN
        e9 = 2'd3;
`else
        e9 = 2'd0;
`endif
        run_job(L19, 40'h0, 9, {6'd0, ref_swap(L19, 40'h0)}, 0, 1'b1, L19, 1'b1, 2'd0);
        run_job(L19, 40'h21, 9, {6'd0, ref_swap(L19, 40'h21)}, 2, 1'b1, L231, 1'b1, 2'd0);
        run_job(vb, 40'h0, 9, 60'd0, 0, 1'b0, '0, 1'b1, 2'd1);
        run_job(vz, 40'h21, 9, 60'd0, 0, 1'b0, '0, 1'b1, 2'd1);
        run_job(L19, 40'h0, 0, 60'd0, 0, 1'b1, '0, 1'b1, 2'd2);
        run_job(vx, 40'h4AB6F0DC95, 9, {6'd0, ref_swap(vx, 40'h4AB6F0DC95)}, T - 1,
                1'b0, '0, 1'b0, 2'd0);
        run_job(L19, 40'h0, 8, {6'd0, L19}, 1, 1'b1, L18, 1'b1, 2'd2);
        run_job(L19, 40'h0, 10, {6'h3f, L19}, 0, 1'b1, L19, 1'b1, 2'd2);
        run_job(L19, 40'h3, 9, {6'd0, L19}, 0, 1'b1, L19, 1'b1, e9);
        run_reset_job(vx, 40'h21);

        // Engine chatter while idle must be ignored
        out_valid = 1'b1; out_data = 6'd7;
        repeat (3) @(posedge clk);
        #1;
        out_valid = 1'b0; out_data = 6'd0;
        run_job(vx, 40'h0, 9, {6'd0, vx}, 3, 1'b1, vx, 1'b1, 2'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
